// File: rtl/knn_pkg.sv
// Shared constants for the K-nearest-neighbour classifier: entry layout,
// derived widths and the vote FSM encoding.
package knn_pkg;

  localparam int DATA_W    = 32;
  localparam int LABEL_W   = 8;
  localparam int DATA_INFO = DATA_W + LABEL_W;
  localparam int K         = 4;
  localparam int NCLASS    = 10;

  localparam int CNT_W  = $clog2(K + 1);
  localparam int ADDR_W = $clog2(K);
  localparam int CLS_W  = $clog2(NCLASS);

  // Entry layout {dist, label}, also used by the insert/distance datapath
  localparam int DIST_MSB  = DATA_INFO - 1;
  localparam int DIST_LSB  = LABEL_W;
  localparam int LABEL_MSB = LABEL_W - 1;
  localparam int LABEL_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/knn_label_hist.sv
// Per-class vote counters plus the list index of each class's nearest member.
module knn_label_hist
  import knn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [CLS_W-1:0]  inc_cls,
  input  logic [ADDR_W-1:0] inc_idx,
  input  logic [CLS_W-1:0]  rd_cls,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [ADDR_W-1:0] rd_first
);

  logic [CNT_W-1:0]  cnt   [NCLASS];
  logic [ADDR_W-1:0] first [NCLASS];

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      for (int unsigned c = 0; c < NCLASS; c++) begin
        cnt[c]   <= '0;
        first[c] <= '0;
      end
    end else if (inc) begin
      cnt[inc_cls] <= cnt[inc_cls] + CNT_W'(1);
      // Entries arrive nearest-first, so the first hit is the closest member
      if (cnt[inc_cls] == '0)
        first[inc_cls] <= inc_idx;
    end
  end

  assign rd_cnt   = cnt[rd_cls];
  assign rd_first = first[rd_cls];

endmodule

// File: rtl/knn_vote.sv
// Reads the sorted neighbour list, histograms the labels and picks the
// majority class, breaking ties toward the class with the nearest member.
module knn_vote
  import knn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_valid,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_INFO-1:0] rd_data,
  output logic [LABEL_W-1:0]   label,
  output logic [CNT_W-1:0]     votes,
  output logic                 done,
  output logic                 busy,
  output logic                 empty,
  output logic                 bad_label
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  n_lat;
  logic              cap_vld;
  logic [ADDR_W-1:0] cap_idx;
  logic [CLS_W-1:0]  scan_c;
  logic [CLS_W-1:0]  best_label;
  logic [CNT_W-1:0]  best_cnt;
  logic [ADDR_W-1:0] best_first;

  logic [LABEL_W-1:0] cap_label;
  logic               label_ok;
  logic               hist_clr;
  logic               hist_inc;
  logic [CNT_W-1:0]   h_cnt;
  logic [ADDR_W-1:0]  h_first;
  logic               replace;
  logic               last_cls;
  logic               unused_dist;

  assign cap_label   = rd_data[LABEL_MSB:LABEL_LSB];
  assign unused_dist = ^rd_data[DIST_MSB:DIST_LSB];
  assign label_ok    = cap_label < LABEL_W'(NCLASS);
  assign hist_clr    = (state == ST_IDLE) && start;
  assign hist_inc    = (state == ST_READ) && cap_vld && label_ok;
  assign last_cls    = scan_c == CLS_W'(NCLASS - 1);

  // Zero-count classes can never replace: equality needs best_cnt > 0
  assign replace = (h_cnt > best_cnt) ||
                   ((h_cnt == best_cnt) && (best_cnt != '0) && (h_first < best_first));

  knn_label_hist u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (hist_clr),
    .inc      (hist_inc),
    .inc_cls  (cap_label[CLS_W-1:0]),
    .inc_idx  (cap_idx),
    .rd_cls   (scan_c),
    .rd_cnt   (h_cnt),
    .rd_first (h_first)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      n_lat      <= '0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      scan_c     <= '0;
      best_label <= '0;
      best_cnt   <= '0;
      best_first <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      label      <= '0;
      votes      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      empty      <= 1'b0;
      bad_label  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat      <= (n_valid > CNT_W'(K)) ? CNT_W'(K) : n_valid;
            empty      <= 1'b0;
            bad_label  <= 1'b0;
            cap_vld    <= 1'b0;
            scan_c     <= '0;
            best_label <= '0;
            best_cnt   <= '0;
            best_first <= '0;
            if (n_valid == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              empty <= 1'b1;
              label <= '0;
              votes <= '0;
            end else begin
              state   <= ST_READ;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        ST_READ: begin
          // Read data lags rd_en by one cycle; cap_vld/cap_idx track that lag
          cap_vld <= rd_en;
          cap_idx <= rd_addr;
          if (rd_en) begin
            if (CNT_W'(rd_addr) + CNT_W'(1) == n_lat)
              rd_en <= 1'b0;
            else
              rd_addr <= rd_addr + ADDR_W'(1);
          end
          if (cap_vld && !label_ok)
            bad_label <= 1'b1;
          if (cap_vld && !rd_en) begin
            state   <= ST_SCAN;
            rd_addr <= '0;
          end
        end
        ST_SCAN: begin
          if (replace) begin
            best_label <= scan_c;
            best_cnt   <= h_cnt;
            best_first <= h_first;
          end
          if (last_cls) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            label <= {{(LABEL_W - CLS_W){1'b0}}, (replace ? scan_c : best_label)};
            votes <= replace ? h_cnt : best_cnt;
          end else begin
            scan_c <= scan_c + CLS_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Bench for knn_vote: registered neighbour-list model, behavioural vote model
// and a per-cycle compare process, driven by directed and random passes.
module tb_knn_vote;
  import knn_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [CNT_W-1:0]     n_valid = '0;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_INFO-1:0] rd_data;
  logic [LABEL_W-1:0]   label;
  logic [CNT_W-1:0]     votes;
  logic                 done, busy, empty, bad_label;

  logic [DATA_INFO-1:0] lst [K];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  knn_vote dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_valid   (n_valid),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .label     (label),
    .votes     (votes),
    .done      (done),
    .busy      (busy),
    .empty     (empty),
    .bad_label (bad_label)
  );

  // Registered read port; junk is returned when not strobed
  always @(posedge clk)
    rd_data <= rd_en ? lst[rd_addr] : {32'($urandom()), 8'($urandom())};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Majority label; ties go to the class that appears earliest in the list
  function automatic void model_vote(input int n, output int lbl, output int vts, output bit bad);
    int cnt [NCLASS];
    int l;
    int mx;
    bit found;
    bad = 1'b0; lbl = 0; vts = 0; mx = 0; found = 1'b0;
    for (int c = 0; c < NCLASS; c++) cnt[c] = 0;
    for (int i = 0; i < n; i++) begin
      l = int'(lst[i][LABEL_MSB:LABEL_LSB]);
      if (l < NCLASS) cnt[l]++;
      else bad = 1'b1;
    end
    for (int c = 0; c < NCLASS; c++) if (cnt[c] > mx) mx = cnt[c];
    for (int i = 0; i < n; i++) begin
      l = int'(lst[i][LABEL_MSB:LABEL_LSB]);
      if (!found && mx > 0 && l < NCLASS && cnt[l] == mx) begin
        lbl = l; vts = mx; found = 1'b1;
      end
    end
  endfunction

  bit m_act = 1'b0;
  bit chk_en = 1'b0;
  int m_c, m_n, m_lat, m_label, m_votes;
  bit m_bad, m_empty;
  int h_label = 0, h_votes = 0;
  bit h_bad = 1'b0, h_empty = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_act = 1'b0; h_label = 0; h_votes = 0; h_bad = 1'b0; h_empty = 1'b0;
      chk_en = 1'b1;
    end else if (m_act) begin
      if (m_c == m_lat) begin
        m_act = 1'b0;
        h_label = m_label; h_votes = m_votes; h_bad = m_bad; h_empty = m_empty;
      end else begin
        m_c++;
      end
    end else if (start) begin
      m_n = (int'(n_valid) > K) ? K : int'(n_valid);
      model_vote(m_n, m_label, m_votes, m_bad);
      m_empty = (m_n == 0);
      m_lat = (m_n == 0) ? 1 : m_n + 2 + NCLASS;
      m_c = 1;
      m_act = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!m_act) begin
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_rd_en", int'(rd_en), 0);
        chk("held_label", int'(label), h_label);
        chk("held_votes", int'(votes), h_votes);
        chk("held_empty", int'(empty), int'(h_empty));
        chk("held_bad", int'(bad_label), int'(h_bad));
      end else begin
        chk("rd_en", int'(rd_en), int'(m_c <= m_n));
        if (m_c <= m_n) chk("rd_addr", int'(rd_addr), m_c - 1);
        chk("done", int'(done), int'(m_c == m_lat));
        chk("busy", int'(busy), int'(m_c < m_lat));
        chk("empty", int'(empty), int'(m_empty));
        if (m_c < m_lat) begin
          chk("pass_label_held", int'(label), h_label);
          chk("pass_votes_held", int'(votes), h_votes);
        end else begin
          chk("res_label", int'(label), m_label);
          chk("res_votes", int'(votes), m_votes);
          chk("res_bad", int'(bad_label), int'(m_bad));
        end
      end
    end
  end

  task automatic load(input int l0, input int l1, input int l2, input int l3);
    int t [4];
    t = '{l0, l1, l2, l3};
    for (int i = 0; i < K; i++) lst[i] = {32'($urandom()), 8'(t[i])};
  endtask

  // Returns at the negedge of the done cycle, or cycle 40 if none arrives
  task automatic run_pass(input int n, input int restart_cyc, input int rst_cyc, output int cyc);
    @(negedge clk);
    start = 1'b1;
    n_valid = CNT_W'(n);
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    while (!done && cyc < 40) begin
      start = (cyc == restart_cyc);
      if (cyc == rst_cyc) rst = 1'b0;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      rst = 1'b1;
      if (cyc == rst_cyc + 1) begin
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_busy", int'(busy), 0);
      end
    end
  endtask

  initial begin
    int cyc;
    int t [4];
    for (int i = 0; i < K; i++) lst[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    load(3, 3, 7, 1);
    run_pass(4, -1, -1, cyc);
    chk("t1_latency", cyc, 16);
    chk("t1_model_label", m_label, 3);
    chk("t1_label", int'(label), 3);
    chk("t1_votes", int'(votes), 2);
    chk("t1_bad", int'(bad_label), 0);
    chk("t1_empty", int'(empty), 0);

    load(5, 2, 2, 5);
    run_pass(4, -1, -1, cyc);
    chk("tie_model_label", m_label, 5);
    chk("tie_label", int'(label), 5);
    chk("tie_votes", int'(votes), 2);

    run_pass(0, -1, -1, cyc);
    chk("empty_latency", cyc, 1);
    chk("empty_flag", int'(empty), 1);
    chk("empty_label", int'(label), 0);
    chk("empty_votes", int'(votes), 0);

    load(12, 4, 4, 9);
    run_pass(4, -1, -1, cyc);
    chk("bad_flag", int'(bad_label), 1);
    chk("bad_label_win", int'(label), 4);
    chk("bad_votes", int'(votes), 2);

    load(12, 200, 3, 3);
    run_pass(2, -1, -1, cyc);
    chk("allbad_model_votes", m_votes, 0);
    chk("allbad_label", int'(label), 0);
    chk("allbad_votes", int'(votes), 0);
    chk("allbad_flag", int'(bad_label), 1);

    load(1, 8, 8, 2);
    run_pass(4, 5, -1, cyc);
    chk("restart_latency", cyc, 16);
    chk("restart_label", int'(label), 8);

    load(7, 7, 7, 7);
    run_pass(4, -1, 3, cyc);
    chk("rst_no_done", int'(done), 0);
    chk("rst_label", int'(label), 0);

    load(5, 5, 5, 3);
    run_pass(4, -1, -1, cyc);
    chk("post_rst_label", int'(label), 5);
    chk("post_rst_votes", int'(votes), 3);

    load(9, 9, 1, 2);
    run_pass(4, -1, -1, cyc);
    chk("b2b_a_label", int'(label), 9);
    load(6, 0, 0, 0);
    run_pass(4, -1, -1, cyc);
    chk("b2b_latency", cyc, 16);
    chk("b2b_label", int'(label), 0);
    chk("b2b_votes", int'(votes), 3);

    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 4; i++)
        t[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(NCLASS, 255))
                                           : int'($urandom_range(0, 4));
      load(t[0], t[1], t[2], t[3]);
      run_pass(int'($urandom_range(0, 7)), -1, -1, cyc);
      chk("rand_done_seen", int'(done), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
